// File: rtl/decode_stage_pipelined_pkg.sv
// rtl/decode_stage_pipelined_pkg.sv - RISC-V opcode/funct constants and ALU operation codes
package decode_stage_pipelined_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADDITION       = 5'd0,
    ALU_SUBTRACTION    = 5'd1,
    ALU_MULTIPLICATION = 5'd2,
    ALU_JALR           = 5'd3,
    ALU_JAL            = 5'd4,
    ALU_BEQ            = 5'd5,
    ALU_BLT            = 5'd6,
    ALU_BGE            = 5'd7,
    ALU_BLTU           = 5'd8,
    ALU_BGEU           = 5'd9
  } alu_op_e;

endpackage

// File: rtl/decode_stage_pipelined_if.sv
// rtl/decode_stage_pipelined_if.sv - fetch-side input and execute-side output bundle of the decode stage
interface decode_stage_pipelined_if #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic [XLEN-1:0]     in_pc;
  logic [XLEN-1:0]     in_next_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     operand1;
  logic [XLEN-1:0]     operand2;
  logic [REG_AW-1:0]   operand1_key;
  logic [REG_AW-1:0]   operand2_key;
  logic [ALU_OP_W-1:0] alu_operation;
  logic                dest_register_enable;
  logic [REG_AW-1:0]   dest_register_number;
  logic                is_load;
  logic                is_store;
  logic                illegal;
  logic [XLEN-1:0]     branch_dest;
  logic [XLEN-1:0]     source2_reg_value;
  logic [XLEN-1:0]     out_next_pc;

  modport master (
    output in_valid, instr, in_pc, in_next_pc, flush, out_ready,
    input  in_ready, out_valid, operand1, operand2, operand1_key, operand2_key,
           alu_operation, dest_register_enable, dest_register_number,
           is_load, is_store, illegal, branch_dest, source2_reg_value, out_next_pc
  );

  modport slave (
    input  in_valid, instr, in_pc, in_next_pc, flush, out_ready,
    output in_ready, out_valid, operand1, operand2, operand1_key, operand2_key,
           alu_operation, dest_register_enable, dest_register_number,
           is_load, is_store, illegal, branch_dest, source2_reg_value, out_next_pc
  );
endinterface

// File: rtl/decode_stage_pipelined_decode_logic.sv
// rtl/decode_stage_pipelined_decode_logic.sv - combinational instruction decode into the next output bundle
import decode_stage_pipelined_pkg::*;

module decode_logic #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5
) (
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     rs1_value,
  input  logic [XLEN-1:0]     rs2_value,
  output logic [XLEN-1:0]     operand1,
  output logic [XLEN-1:0]     operand2,
  output logic [REG_AW-1:0]   operand1_key,
  output logic [REG_AW-1:0]   operand2_key,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                dest_register_enable,
  output logic [REG_AW-1:0]   dest_register_number,
  output logic                is_load,
  output logic                is_store,
  output logic                illegal,
  output logic [XLEN-1:0]     branch_dest,
  output logic                uses_rs1,
  output logic                uses_rs2
);
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  alu_op_e           alu_code;
  logic              rd_en, bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    alu_code    = ALU_ADDITION;
    operand1    = '0;
    operand2    = '0;
    branch_dest = '0;
    rd_en       = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    bad         = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        operand1 = rs1_value;
        operand2 = rs2_value;
        rd_en    = 1'b1;
        if (funct3 == F3_ADD && funct7 == F7_BASE)        alu_code = ALU_ADDITION;
        else if (funct3 == F3_ADD && funct7 == F7_SUB)    alu_code = ALU_SUBTRACTION;
        else if (funct3 == F3_ADD && funct7 == F7_MULDIV) alu_code = ALU_MULTIPLICATION;
        else bad = 1'b1;
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        operand1 = rs1_value;
        operand2 = XLEN'(imm_i);
        rd_en    = 1'b1;
        bad      = (funct3 != F3_ADD);
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        operand1 = rs1_value;
        operand2 = XLEN'(imm_i);
        rd_en    = 1'b1;
        is_load  = 1'b1;
        bad      = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        operand1 = rs1_value;
        operand2 = XLEN'(imm_s);
        is_store = 1'b1;
        bad      = (funct3 > F3_SW);
      end
      OPC_BRANCH: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        operand1    = rs1_value;
        operand2    = rs2_value;
        branch_dest = pc + XLEN'(imm_b);
        case (funct3)
          F3_BEQ:  alu_code = ALU_BEQ;
          F3_BLT:  alu_code = ALU_BLT;
          F3_BGE:  alu_code = ALU_BGE;
          F3_BLTU: alu_code = ALU_BLTU;
          F3_BGEU: alu_code = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JALR: begin
        uses_rs1    = 1'b1;
        operand1    = rs1_value;
        operand2    = XLEN'(imm_i);
        operand2[0] = 1'b0;
        rd_en       = 1'b1;
        alu_code    = ALU_JALR;
        bad         = (funct3 != F3_ADD);
      end
      OPC_JAL: begin
        operand1    = pc;
        operand2    = XLEN'(imm_j);
        branch_dest = pc + XLEN'(imm_j);
        rd_en       = 1'b1;
        alu_code    = ALU_JAL;
      end
      OPC_LUI: begin
        operand2 = XLEN'(imm_u);
        rd_en    = 1'b1;
      end
      OPC_AUIPC: begin
        operand1 = pc;
        operand2 = XLEN'(imm_u);
        rd_en    = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // Anything not decodable collapses to a NOP so execute never sees half-decoded fields.
    if (bad) begin
      alu_code    = ALU_ADDITION;
      operand1    = '0;
      operand2    = '0;
      branch_dest = '0;
      rd_en       = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
  end

  assign illegal              = bad;
  assign dest_register_enable = rd_en;
  assign dest_register_number = rd_en ? REG_AW'(instr[11:7]) : '0;
  assign operand1_key         = uses_rs1 ? REG_AW'(instr[19:15]) : '0;
  assign operand2_key         = uses_rs2 ? REG_AW'(instr[24:20]) : '0;
  assign alu_operation        = ALU_OP_W'(alu_code);

endmodule

// File: rtl/decode_stage_pipelined.sv
// rtl/decode_stage_pipelined.sv - decode pipeline stage with ready/valid handshake, load-use hazard and flush
import decode_stage_pipelined_pkg::*;

module decode_stage_pipelined #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  decode_stage_pipelined_if.slave bus,
  output logic [REG_AW-1:0]      source1_register_key,
  output logic [REG_AW-1:0]      source2_register_key,
  input  logic [XLEN-1:0]        source1_register_value,
  input  logic [XLEN-1:0]        source2_register_value,
  output logic [CNT_W-1:0]       stall_count
);
  typedef struct packed {
    logic [XLEN-1:0]     operand1;
    logic [XLEN-1:0]     operand2;
    logic [REG_AW-1:0]   operand1_key;
    logic [REG_AW-1:0]   operand2_key;
    logic [ALU_OP_W-1:0] alu_operation;
    logic                dest_register_enable;
    logic [REG_AW-1:0]   dest_register_number;
    logic                is_load;
    logic                is_store;
    logic                illegal;
    logic [XLEN-1:0]     branch_dest;
    logic [XLEN-1:0]     source2_reg_value;
    logic [XLEN-1:0]     out_next_pc;
  } bundle_t;

  bundle_t           dec, bundle_d, bundle_q;
  logic              out_valid_d, out_valid_q;
  logic [CNT_W-1:0]  stall_count_d, stall_count_q;
  logic              en, hazard, uses_rs1, uses_rs2;

  assign source1_register_key = REG_AW'(bus.instr[19:15]);
  assign source2_register_key = REG_AW'(bus.instr[24:20]);

  decode_logic #(.XLEN(XLEN), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)) u_decode (
    .instr                (bus.instr),
    .pc                   (bus.in_pc),
    .rs1_value            (source1_register_value),
    .rs2_value            (source2_register_value),
    .operand1             (dec.operand1),
    .operand2             (dec.operand2),
    .operand1_key         (dec.operand1_key),
    .operand2_key         (dec.operand2_key),
    .alu_operation        (dec.alu_operation),
    .dest_register_enable (dec.dest_register_enable),
    .dest_register_number (dec.dest_register_number),
    .is_load              (dec.is_load),
    .is_store             (dec.is_store),
    .illegal              (dec.illegal),
    .branch_dest          (dec.branch_dest),
    .uses_rs1             (uses_rs1),
    .uses_rs2             (uses_rs2)
  );

  assign dec.source2_reg_value = source2_register_value;
  assign dec.out_next_pc       = bus.in_next_pc;

  // Load result is not available until after execute, so a dependent instruction waits one bubble.
  assign hazard = bus.in_valid && out_valid_q && bundle_q.is_load
               && (bundle_q.dest_register_number != '0)
               && ((uses_rs1 && source1_register_key == bundle_q.dest_register_number)
                || (uses_rs2 && source2_register_key == bundle_q.dest_register_number));

  always_comb begin
    en            = bus.out_ready || !out_valid_q;
    bus.in_ready  = bus.flush || (en && !hazard);
    out_valid_d   = out_valid_q;
    bundle_d      = bundle_q;
    stall_count_d = stall_count_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (en) begin
      if (hazard) begin
        out_valid_d = 1'b0;
        if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
      end else if (bus.in_valid) begin
        out_valid_d = 1'b1;
        bundle_d    = dec;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q            <= 1'b0;
      stall_count_q          <= '0;
      bundle_q               <= '0;
      bundle_q.alu_operation <= ALU_OP_W'(ALU_ADDITION);
    end else begin
      out_valid_q   <= out_valid_d;
      stall_count_q <= stall_count_d;
      bundle_q      <= bundle_d;
    end
  end

  assign bus.out_valid            = out_valid_q;
  assign bus.operand1             = bundle_q.operand1;
  assign bus.operand2             = bundle_q.operand2;
  assign bus.operand1_key         = bundle_q.operand1_key;
  assign bus.operand2_key         = bundle_q.operand2_key;
  assign bus.alu_operation        = bundle_q.alu_operation;
  assign bus.dest_register_enable = bundle_q.dest_register_enable;
  assign bus.dest_register_number = bundle_q.dest_register_number;
  assign bus.is_load              = bundle_q.is_load;
  assign bus.is_store             = bundle_q.is_store;
  assign bus.illegal              = bundle_q.illegal;
  assign bus.branch_dest          = bundle_q.branch_dest;
  assign bus.source2_reg_value    = bundle_q.source2_reg_value;
  assign bus.out_next_pc          = bundle_q.out_next_pc;
  assign stall_count              = stall_count_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb/tb_decode_stage_pipelined.sv - directed self-checking bench for decode_stage_pipelined
module tb_decode_stage_pipelined;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  source1_register_key, source2_register_key;
  logic [31:0] source1_register_value, source2_register_value;
  logic [3:0]  stall_count;
  int          total = 0;
  int          bad = 0;

  localparam logic [31:0] I_ADDI = 32'hFFF08293;
  localparam logic [31:0] I_SUB  = 32'h40838333;
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
  localparam logic [31:0] I_JAL  = 32'h001000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_LUI  = 32'h123453B7;
  localparam logic [31:0] I_LW   = 32'h00012183;
  localparam logic [31:0] I_ADD  = 32'h00118233;

  always #5 clk = ~clk;

  decode_stage_pipelined_if #(.XLEN(32), .REG_AW(5), .ALU_OP_W(5)) bus ();

  decode_stage_pipelined #(.XLEN(32), .REG_AW(5), .ALU_OP_W(5), .CNT_W(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .bus                    (bus),
    .source1_register_key   (source1_register_key),
    .source2_register_key   (source2_register_key),
    .source1_register_value (source1_register_value),
    .source2_register_value (source2_register_value),
    .stall_count            (stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.in_pc = '0;
    bus.in_next_pc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    source1_register_value = '0;
    source2_register_value = '0;
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu", bus.alu_operation, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_dest_en", bus.dest_register_enable, 0);
    chk("rst_operand1", bus.operand1, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    bus.instr = I_ADDI;
    bus.in_pc = 32'h40;
    bus.in_next_pc = 32'h44;
    source1_register_value = 32'd7;
    source2_register_value = 32'h55;
    bus.in_valid = 1'b1;
    #1;
    chk("addi_rs1_key", source1_register_key, 1);
    step();
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_op1", bus.operand1, 32'd7);
    chk("addi_op2", bus.operand2, 32'hFFFFFFFF);
    chk("addi_dest_en", bus.dest_register_enable, 1);
    chk("addi_dest", bus.dest_register_number, 5);
    chk("addi_next_pc", bus.out_next_pc, 32'h44);
    chk("addi_rs2_raw", bus.source2_reg_value, 32'h55);

    bus.instr = I_SUB;
    source1_register_value = 32'd10;
    source2_register_value = 32'd3;
    step();
    chk("sub_alu", bus.alu_operation, 1);
    chk("sub_op1", bus.operand1, 32'd10);
    chk("sub_op2", bus.operand2, 32'd3);
    chk("sub_op2_key", bus.operand2_key, 8);
    chk("sub_dest", bus.dest_register_number, 6);

    bus.instr = I_BEQ;
    bus.in_pc = 32'h200;
    step();
    chk("beq_dest", bus.branch_dest, 32'h1F8);
    chk("beq_alu", bus.alu_operation, 5);
    chk("beq_dest_en", bus.dest_register_enable, 0);

    bus.instr = I_JAL;
    bus.in_pc = 32'h100;
    step();
    chk("jal_branch_dest", bus.branch_dest, 32'h900);
    chk("jal_alu", bus.alu_operation, 4);
    chk("jal_dest", bus.dest_register_number, 1);
    chk("jal_op1", bus.operand1, 32'h100);

    bus.instr = I_BAD;
    step();
    chk("bad_illegal", bus.illegal, 1);
    chk("bad_valid", bus.out_valid, 1);
    chk("bad_dest_en", bus.dest_register_enable, 0);

    bus.instr = I_LUI;
    step();
    chk("lui_op1", bus.operand1, 0);
    chk("lui_op2", bus.operand2, 32'h12345000);
    chk("lui_dest", bus.dest_register_number, 7);

    bus.instr = I_LW;
    source1_register_value = 32'h1000;
    step();
    chk("lw_is_load", bus.is_load, 1);
    chk("lw_dest", bus.dest_register_number, 3);
    bus.instr = I_ADD;
    source1_register_value = 32'd5;
    source2_register_value = 32'd6;
    #1;
    chk("luse_in_ready", bus.in_ready, 0);
    step();
    chk("luse_bubble", bus.out_valid, 0);
    chk("luse_stall", stall_count, 1);
    chk("luse_ready_after", bus.in_ready, 1);
    step();
    chk("add_valid", bus.out_valid, 1);
    chk("add_dest", bus.dest_register_number, 4);
    chk("add_op1", bus.operand1, 32'd5);

    bus.instr = I_SUB;
    source1_register_value = 32'd10;
    source2_register_value = 32'd3;
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_dest", bus.dest_register_number, 4);
      chk("bp_op1", bus.operand1, 32'd5);
      chk("bp_in_ready_hold", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    step();
    chk("bp_sub_dest", bus.dest_register_number, 6);
    chk("bp_sub_alu", bus.alu_operation, 1);

    bus.out_ready = 1'b0;
    bus.instr = I_ADDI;
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", bus.in_ready, 1);
    step();
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_stall", stall_count, 1);
    bus.flush = 1'b0;

    bus.out_ready = 1'b1;
    bus.instr = I_LW;
    step();
    chk("hf_lw_load", bus.is_load, 1);
    bus.out_ready = 1'b0;
    bus.instr = I_ADD;
    bus.flush = 1'b1;
    step();
    chk("hf_valid", bus.out_valid, 0);
    chk("hf_stall", stall_count, 1);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.instr = I_LW;
      step();
      bus.instr = I_ADD;
      step();
      if (i == 13) chk("sat_reach", stall_count, 4'hF);
    end
    chk("sat_hold", stall_count, 4'hF);

    bus.instr = I_LW;
    step();
    bus.instr = I_ADD;
    #1;
    chk("rs_hazard", bus.in_ready, 0);
    reset = 1'b1;
    step();
    chk("rs_valid", bus.out_valid, 0);
    chk("rs_is_load", bus.is_load, 0);
    chk("rs_dest", bus.dest_register_number, 0);
    chk("rs_stall", stall_count, 0);
    chk("rs_op1", bus.operand1, 0);
    chk("rs_branch_dest", bus.branch_dest, 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rs_in_ready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipelined.md
DECODE_STAGE_PIPELINED -- requirements
Module: decode_stage_pipelined

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; REG_AW, default 5, register-key width; ALU_OP_W, default 5, ALU-op width; CNT_W, default 16, stall-counter width.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  instruction and PCs valid; in_ready  output  1  stage accepts this cycle.
REQ-005 instr  input  32  fetched instruction; in_pc  input  XLEN  its PC; in_next_pc  input  XLEN  fall-through PC.
REQ-006 flush  input  1  kill in-flight and incoming instruction.
REQ-007 source1_register_key, source2_register_key  output  REG_AW  combinational rs1/rs2 to register file.
REQ-008 source1_register_value, source2_register_value  input  XLEN  register-file read data, same cycle.
REQ-009 out_valid  output  1  output bundle valid; out_ready  input  1  execute accepts.
REQ-010 Output bundle, all registered: operand1, operand2 (XLEN); operand1_key, operand2_key (REG_AW); alu_operation (ALU_OP_W); dest_register_enable (1); dest_register_number (REG_AW); is_load, is_store, illegal (1 each); branch_dest, source2_reg_value, out_next_pc (XLEN).
REQ-011 stall_count  output  CNT_W  saturating count of hazard-bubble cycles.

Function
REQ-012 Pipe enable en SHALL be out_ready OR NOT out_valid; bundle registers SHALL load only when en=1 and otherwise hold every output bit unchanged.
REQ-013 hazard SHALL be 1 when out_valid=1, is_load=1, dest_register_number!=0 and the incoming instruction reads that register as rs1 (OP, OP_IMM, LOAD, STORE, BRANCH, JALR) or as rs2 (OP, STORE, BRANCH).
REQ-014 in_ready SHALL equal flush OR (en AND NOT hazard).
REQ-015 On en=1 with hazard=1 and no flush, the stage SHALL load a bubble (out_valid=0) and increment stall_count, saturating at all-ones.
REQ-016 On in_valid AND in_ready with no flush, the decoded bundle SHALL be registered with out_valid=1; latency in_valid to out_valid is exactly one cycle.
REQ-017 flush SHALL take priority: the incoming instruction is consumed and dropped, and out_valid SHALL be 0 next cycle regardless of out_ready.
REQ-018 Operand decode SHALL be: OP op1=rs1, op2=rs2; OP_IMM/LOAD op1=rs1, op2=sext(immI); STORE op1=rs1, op2=sext(immS); BRANCH op1=rs1, op2=rs2; JALR op1=rs1, op2=sext(immI) with bit0 cleared; LUI op1=0, op2=immU; AUIPC op1=in_pc, op2=immU; JAL op1=in_pc, op2=sext(immJ).
REQ-019 branch_dest SHALL be in_pc+sext(immB) for BRANCH, in_pc+sext(immJ) for JAL, else 0; addition modulo 2^XLEN.
REQ-020 alu_operation SHALL be: ADD/ADDI/LOAD/STORE/LUI/AUIPC ADDITION; SUB SUBTRACTION; MUL MULTIPLICATION; JALR ALU_JALR; JAL ALU_JAL; BEQ/BLT/BGE/BLTU/BGEU the matching ALU_B* code; default ADDITION.
REQ-021 dest_register_enable SHALL be 1 for OP, OP_IMM, LOAD, JALR, JAL, LUI, AUIPC, with dest_register_number=rd; otherwise 0 with x0.
REQ-022 An unlisted opcode or unsupported funct3/funct7 SHALL produce a NOP bundle (ADDITION, dest disabled) with illegal=1 and out_valid=1.
REQ-023 source2_reg_value SHALL carry raw rs2 data and out_next_pc SHALL carry in_next_pc alongside the bundle.
REQ-024 When hazard, flush and out_ready=0 coincide, flush SHALL win and stall_count SHALL NOT increment.

Reset
REQ-025 On reset=1 at a clk edge: out_valid=0, illegal/is_load/is_store=0, dest_register_enable=0, dest_register_number=0, keys=0, all XLEN outputs=0, alu_operation=ADDITION, stall_count=0.
REQ-026 Reset mid-operation SHALL discard any held bundle; in_ready SHALL be valid combinationally from the first post-reset cycle.

Structure
REQ-027 Opcode and funct constants, including new LUI, AUIPC and JAL, SHALL be in the shared RISC-V constants package; ALU_JAL SHALL be added to the shared ALU constants package.
REQ-028 Combinational decode SHALL be a sub-module decode_logic (instr, pc, register values in; next bundle out); this block adds handshake, hazard and registers.

Verification
REQ-029 ADDI x5,x1,-1 with rs1=7, out_ready=1 -> next cycle out_valid=1, operand1=7, operand2=0xFFFFFFFF, dest x5 enabled.
REQ-030 LW x3,0(x2) then ADD x4,x3,x1 back-to-back -> one bubble, in_ready=0 for one cycle, stall_count=1, ADD issues the cycle after.
REQ-031 out_ready=0 for 3 cycles with a valid bundle held -> all outputs stable, in_ready=0, no instruction lost.
REQ-032 flush asserted with a valid held bundle and out_ready=0 -> out_valid=0 next cycle, stall_count unchanged.
REQ-033 JAL x1,+2048 at in_pc=0x100 -> branch_dest=0x900, alu_operation=ALU_JAL, dest x1; opcode 0x7F -> illegal=1.
REQ-034 Preset stall_count to all-ones via repeated hazards -> holds at all-ones; reset mid-stall -> all outputs at reset values next cycle.
